// File: rtl/csa_resolve.sv
// csa_resolve: chunk-serial carry-propagate resolver producing s + 2*c from a carry-save pair.
// Define CSA_RESOLVE_BYPASS_EN to fast-path pairs whose carry vector is zero.
module csa_resolve #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] sum,
    output logic             busy
);
    localparam int W2 = WIDTH + 2;
    localparam int NCH = (W2 + CHUNK - 1) / CHUNK;
    localparam int IW = $clog2(NCH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, BYP} state_t;
    state_t state;
    logic [W2-1:0] op_a, op_b, ins, mask;
    logic [IW-1:0] idx;
    logic carry;
    logic [31:0] sh;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0] tmp;
    assign in_ready = state == IDLE;
    assign busy = state == BUSY;
    assign out_valid = state == DONE;
    // bits shifted past the top of sum fall off, which truncates the last chunk
    always_comb begin
        sh = 32'(idx) * 32'(CHUNK);
        a_sl = CHUNK'(op_a >> sh);
        b_sl = CHUNK'(op_b >> sh);
        tmp = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        ins = W2'(tmp[CHUNK-1:0]) << sh;
        mask = W2'({CHUNK{1'b1}}) << sh;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a <= '0;
            op_b <= '0;
            idx <= '0;
            carry <= 1'b0;
            sum <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_a <= {2'b0, s};
                    op_b <= {1'b0, c, 1'b0};
                    idx <= '0;
                    carry <= 1'b0;
                    state <= BUSY;
`ifdef CSA_RESOLVE_BYPASS_EN
                    if (c == '0) begin
                        sum <= {2'b0, s};
                        state <= BYP;
                    end
`endif
                end
                BUSY: begin
                    sum <= (sum & ~mask) | ins;
                    carry <= tmp[CHUNK];
                    idx <= idx + 1'b1;
                    if (idx == IW'(NCH - 1)) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                // bypass holds one cycle so the result appears one edge after accept
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve: arithmetic model plus directed vectors for csa_resolve.
module tb_csa_resolve;
    localparam int NCH = 5;
`ifdef CSA_RESOLVE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] s = '0, c = '0;
    logic in_ready, out_valid, busy;
    logic [17:0] sum;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    csa_resolve dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // model: one outstanding pair, result s+2c due a fixed number of edges after accept
    logic [17:0] m_exp = '0;
    logic m_pend = 1'b0, m_byp = 1'b0;
    int m_due = 0, cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) m_pend = 1'b0;
        else if (m_pend) begin
            if (cyc - 1 >= m_due && out_ready) m_pend = 1'b0;
        end else if (in_valid) begin
            m_pend = 1'b1;
            m_exp = 18'(s) + 18'(c) + 18'(c);
            m_byp = BYP && c == 16'h0;
            m_due = cyc + (m_byp ? 1 : NCH);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_sum", 32'(sum), 0);
        end else begin
            chk("m_in_ready", 32'(in_ready), 32'(!m_pend));
            chk("m_out_valid", 32'(out_valid), 32'(m_pend && cyc >= m_due));
            chk("m_busy", 32'(busy), 32'(m_pend && cyc < m_due && !m_byp));
            if (m_pend && cyc >= m_due) chk("m_sum", 32'(sum), 32'(m_exp));
        end
    end

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [17:0] want, input int lat);
        int n;
        @(negedge clk);
        #1;
        s = a;
        c = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s = ~a;
        c = ~b;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("sum", 32'(sum), 32'(want));
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] ps[3] = '{16'h0F0F, 16'h8000, 16'h0003};
    logic [15:0] pc[3] = '{16'h00F0, 16'h8000, 16'h7FFF};
    time t[3];

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("init_in_ready", 32'(in_ready), 1);
        chk("init_out_valid", 32'(out_valid), 0);
        chk("init_sum", 32'(sum), 0);
        run(16'h1234, 16'h0001, 18'h01236, NCH);
        chk("model_pin", 32'(m_exp), 32'h01236);
        take();
        run(16'hFFFF, 16'hFFFF, 18'h2FFFD, NCH);
        take();
        run(16'hFFFF, 16'h0001, 18'h10001, NCH);
        for (int i = 0; i < 4; i++) begin
            in_valid = i == 1;
            s = 16'h1111;
            c = 16'h2222;
            @(posedge clk);
            #1;
            chk("hold_sum", 32'(sum), 32'h10001);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_out_valid", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        take();
        run(16'h00A5, 16'h0000, 18'h000A5, BYP ? 1 : NCH);
        take();
        @(negedge clk);
        #1;
        s = 16'hAAAA;
        c = 16'h5555;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", 32'(in_ready), 1);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_sum", 32'(sum), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        run(16'h0001, 16'h0001, 18'h00003, NCH);
        take();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s = ps[i];
            c = pc[i];
            n = 0;
            while (!in_ready && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            @(posedge clk);
            t[i] = $time;
            #1;
        end
        in_valid = 1'b0;
        chk("spacing01", 32'((t[1] - t[0]) / 10), 7);
        chk("spacing12", 32'((t[2] - t[1]) / 10), 7);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_last_sum", 32'(sum), 32'h10001);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csa_resolve.md
# csa_resolve

Sequential carry-propagate resolver for carry-save operands. It accepts a redundant pair (sum vector `s`, carry vector `c`) from the carry-save adder stage and produces the binary result `s + 2*c`. The carry is resolved one CHUNK-bit slice per clock instead of in a single combinational ripple. It sits directly downstream of the 16-bit CSA array and connects to it through a valid/ready handshake.

## Interface
- `WIDTH`, 16: width of the `s` and `c` input vectors.
- `CHUNK`, 4: bits resolved per clock. Must satisfy 1 ≤ CHUNK ≤ WIDTH+2.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: `s`/`c` pair valid.
- `in_ready`  out  1: block can accept a pair.
- `s`  in  WIDTH: carry-save sum vector.
- `c`  in  WIDTH: carry-save carry vector, weight 2.
- `out_valid`  out  1: `sum` valid.
- `out_ready`  in  1: consumer takes `sum`.
- `sum`  out  WIDTH+2: exact `s + 2*c`, no truncation.
- `busy`  out  1: resolution in progress.

## Operation
- NCH = ceil((WIDTH+2)/CHUNK). With the defaults NCH = 5.
- States and transitions:
  - IDLE: `in_ready`=1. On an accept (`in_valid && in_ready`), latch `op_a = {2'b0,s}` and `op_b = {1'b0,c,1'b0}`, clear the carry flop, set the chunk index to 0, and go to BUSY.
  - BUSY: each cycle, compute `{carry, sum[i*CHUNK +: CHUNK]} = op_a slice + op_b slice + carry` and increment the index. The last chunk is truncated to the remaining bits (WIDTH+2 − (NCH−1)*CHUNK). After NCH cycles, go to DONE.
  - DONE: `out_valid`=1 and `sum` is held stable. On `out_ready`, go to IDLE.
- Carry out of the top chunk is always 0, because the maximum result (2^WIDTH−1)·3 fits in WIDTH+2 bits.
- `in_ready` is 1 only in IDLE. Input is never accepted in BUSY or DONE, so there is no simultaneous accept and deliver.
- `busy` = (state == BUSY).
- `sum` is written chunk by chunk during BUSY. Its value is defined only while `out_valid`=1.
- `s` and `c` are sampled only on the accept edge. Later input changes have no effect.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, carry=0, index=0.
- Accept on edge k:
  - `busy`=1 from edge k to edge k+NCH.
  - `out_valid`=1 from edge k+NCH.
  - Latency is NCH cycles (5 with defaults).
- Handshake on edge m (`out_valid && out_ready`): `out_valid`=0 and `in_ready`=1 after edge m. The next accept is possible at edge m+1.
- Peak throughput: one result per NCH+2 cycles.
- `out_ready` held low: DONE persists indefinitely, with `sum` and `out_valid` unchanged.
- `rst` asserted in any state (including mid-BUSY): immediately forces the reset values. The partial result is discarded and never delivered.
- `out_ready` asserted while not in DONE: ignored.

## Configuration
- `CSA_RESOLVE_BYPASS_EN` defined:
  - If `c == 0` at the accept edge k, skip BUSY and enter DONE directly with `sum = {2'b0,s}`.
  - `out_valid` is then 1 from edge k+1, and `busy` stays 0.
  - Nonzero `c` follows the normal NCH-cycle path.
- `CSA_RESOLVE_BYPASS_EN` not defined: every operand pair takes NCH cycles, regardless of `c`.

## Test plan
- After reset release, check `in_ready`=1, `out_valid`=0, `sum`=0. Then accept `s`=0x1234, `c`=0x0001 → `sum`=0x01236, with `out_valid` 5 cycles after the accept.
- `s`=0xFFFF, `c`=0xFFFF → `sum`=0x2FFFD, which exercises the full carry chain across all 5 chunks and the top-bit width.
- `s`=0xFFFF, `c`=0x0001 → `sum`=0x10001. Then hold `out_ready` low for 4 cycles → `sum` stays stable, `in_ready`=0, and an `in_valid` pulse in that window is ignored.
- `s`=0x00A5, `c`=0x0000 → `sum`=0x000A5. `out_valid` rises 1 cycle after the accept with `CSA_RESOLVE_BYPASS_EN` defined, or 5 cycles after without it.
- Accept `s`=0xAAAA, `c`=0x5555, then assert `rst` 2 cycles later → all outputs return to reset values immediately. Next accept `s`=0x0001, `c`=0x0001 → `sum`=0x00003 with no stale carry.
- Back-to-back: `in_valid` and `out_ready` held high with 3 queued pairs → each result is delivered in order, and accepts are spaced NCH+2 = 7 cycles apart.
